// File: rtl/fp_hazard_scoreboard.sv
// FP hazard/forwarding controller: tracks in-flight FP destinations through E1..EDEPTH
// and an iterative div/sqrt, and decides issue, stalls, forward selects and write-back.
module fp_hazard_scoreboard #(
   parameter  int AW        = 5,
   parameter  int DEPTH     = 3,
   parameter  int FWD_STAGE = 3,
   parameter  int DIV_CYC   = 4,
   localparam int SW        = $clog2(DEPTH + 1),
   localparam int CW        = $clog2(DIV_CYC)
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          id_valid,
   input  logic          id_use_fs,
   input  logic          id_use_ft,
   input  logic          id_wf,
   input  logic          id_divsqrt,
   input  logic [AW-1:0] id_fs,
   input  logic [AW-1:0] id_ft,
   input  logic [AW-1:0] id_fd,
   input  logic          stall_ext,
   output logic          issue,
   output logic          wpcir,
   output logic          stall_fp,
   output logic          stall_ds,
   output logic [SW-1:0] fwd_a,
   output logic [SW-1:0] fwd_b,
   output logic          wb_valid,
   output logic [AW-1:0] wb_rn,
   output logic [CW-1:0] ds_cnt
);

   localparam logic [SW-1:0] FWD_K = SW'(FWD_STAGE);

   logic [DEPTH:1]  v;
   logic [AW-1:0]   rn [1:DEPTH];
   logic [SW-1:0]   ka, kb;
   logic            use_a, use_b, stall_a, stall_b;

   // Scan oldest to youngest so the lowest matching stage is the one kept.
   always_comb begin
      ka = '0;
      kb = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (v[k] && (rn[k] == id_fs)) ka = SW'(k);
         if (v[k] && (rn[k] == id_ft)) kb = SW'(k);
      end
   end

   assign use_a    = id_valid & id_use_fs;
   assign use_b    = id_valid & id_use_ft;
   assign stall_a  = use_a && (ka != '0) && (ka < FWD_K);
   assign stall_b  = use_b && (kb != '0) && (kb < FWD_K);
   assign fwd_a    = (use_a && (ka >= FWD_K)) ? ka : '0;
   assign fwd_b    = (use_b && (kb >= FWD_K)) ? kb : '0;

   assign stall_fp = stall_a | stall_b;
   assign stall_ds = (ds_cnt != '0);
   assign issue    = id_valid & ~stall_fp & ~stall_ds & ~stall_ext;
   assign wpcir    = ~(stall_fp | stall_ds | stall_ext);

   assign wb_valid = v[DEPTH];
   assign wb_rn    = rn[DEPTH];

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         v      <= '0;
         ds_cnt <= '0;
         for (int k = 1; k <= DEPTH; k++) rn[k] <= '0;
      end else begin
         // Later stages always drain; E2 takes a bubble while a divide holds E1.
         for (int k = DEPTH; k >= 2; k--) begin
            v[k]  <= (k == 2 && stall_ds) ? 1'b0 : v[k-1];
            rn[k] <= rn[k-1];
         end
         if (!stall_ds) begin
            v[1]  <= issue & id_wf;
            rn[1] <= id_fd;
         end
         if (stall_ds)
            ds_cnt <= ds_cnt - CW'(1);
         else if (issue && id_divsqrt)
            ds_cnt <= CW'(DIV_CYC - 1);
      end
   end

endmodule
